// File: rtl/oled_page_writer.sv
// oled_page_writer
// Streams a 4-page x 128-column OLED frame buffer out through a byte-wide SPI
// serializer. Each page is preceded by a 4-byte addressing command sequence
// (0x22, page, 0x00, 0x10) sent with DC=0, followed by 128 display bytes with DC=1.
// Optional build macro: OLED_PW_INVERT_EN -- when defined, display bytes are
// inverted as they are latched from the frame buffer (command bytes untouched).
module oled_page_writer (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    output logic [8:0] MEM_ADDR,
    input  logic [7:0] MEM_DATA,
    output logic       SPI_EN,
    output logic [7:0] SPI_DATA,
    input  logic       SPI_FIN,
    output logic       DC,
    output logic       BUSY,
    output logic       FIN
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        FETCH,
        LOAD,
        XFER,
        CLEAR,
        NEXT,
        DONE
    } state_t;

    state_t     state_q;
    logic [1:0] page_q;
    logic [6:0] col_q;
    logic [1:0] cmdIdx_q;
    logic       spiEn_q;
    logic [7:0] spiData_q;
    logic       dc_q;
    logic       busy_q;
    logic       fin_q;

    logic [7:0] cmdByte_d;
    logic [7:0] loadByte_d;

    // Page addressing command byte selected by the position in the command sequence
    always_comb begin
        cmdByte_d = 8'h00;
        case (cmdIdx_q)
            2'd0:    cmdByte_d = 8'h22;
            2'd1:    cmdByte_d = {6'b000000, page_q};
            2'd2:    cmdByte_d = 8'h00;
            default: cmdByte_d = 8'h10;
        endcase
    end

    // Display byte as it will be handed to the serializer
    always_comb begin
`ifdef OLED_PW_INVERT_EN
        loadByte_d = ~MEM_DATA;
`else
        loadByte_d = MEM_DATA;
`endif
    end

    // Main sequencer: walks commands and display bytes, handshaking each byte with the serializer
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            page_q    <= 2'd0;
            col_q     <= 7'd0;
            cmdIdx_q  <= 2'd0;
            spiEn_q   <= 1'b0;
            spiData_q <= 8'h00;
            dc_q      <= 1'b0;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    spiEn_q <= 1'b0;
                    dc_q    <= 1'b0;
                    fin_q   <= 1'b0;
                    if (EN) begin
                        page_q   <= 2'd0;
                        col_q    <= 7'd0;
                        cmdIdx_q <= 2'd0;
                        busy_q   <= 1'b1;
                        state_q  <= CMD;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                CMD: begin
                    spiData_q <= cmdByte_d;
                    spiEn_q   <= 1'b1;
                    state_q   <= XFER;
                end
                FETCH: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    spiData_q <= loadByte_d;
                    spiEn_q   <= 1'b1;
                    state_q   <= XFER;
                end
                XFER: begin
                    if (SPI_FIN) begin
                        spiEn_q <= 1'b0;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (!SPI_FIN) begin
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (!EN) begin
                        dc_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        fin_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (!dc_q) begin
                        if (cmdIdx_q != 2'd3) begin
                            cmdIdx_q <= cmdIdx_q + 2'd1;
                            state_q  <= CMD;
                        end else begin
                            dc_q    <= 1'b1;
                            state_q <= FETCH;
                        end
                    end else if (col_q != 7'd127) begin
                        col_q   <= col_q + 7'd1;
                        state_q <= FETCH;
                    end else if (page_q != 2'd3) begin
                        col_q    <= 7'd0;
                        page_q   <= page_q + 2'd1;
                        cmdIdx_q <= 2'd0;
                        dc_q     <= 1'b0;
                        state_q  <= CMD;
                    end else begin
                        busy_q  <= 1'b0;
                        fin_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    if (EN) begin
                        fin_q <= 1'b1;
                    end else begin
                        fin_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign MEM_ADDR = {page_q, col_q};
    assign SPI_EN   = spiEn_q;
    assign SPI_DATA = spiData_q;
    assign DC       = dc_q;
    assign BUSY     = busy_q;
    assign FIN      = fin_q;

endmodule

// File: tb/tb_oled_page_writer.sv
// tb_oled_page_writer
// Self-checking bench for oled_page_writer: synchronous RAM model, SPI serializer
// model with configurable done-hold, and a byte scoreboard fed by the stimulus.
module tb_oled_page_writer;

    logic       CLK;
    logic       RST_N = 1'b1;
    logic       EN = 1'b0;
    logic [8:0] MEM_ADDR;
    logic [7:0] memData;
    logic       SPI_EN;
    logic [7:0] SPI_DATA;
    logic       spiFin;
    logic       DC;
    logic       BUSY;
    logic       FIN;

    oled_page_writer dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .EN       (EN),
        .MEM_ADDR (MEM_ADDR),
        .MEM_DATA (memData),
        .SPI_EN   (SPI_EN),
        .SPI_DATA (SPI_DATA),
        .SPI_FIN  (spiFin),
        .DC       (DC),
        .BUSY     (BUSY),
        .FIN      (FIN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int testsRun = 0;
    int testsFailed = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Frame buffer: data appears one clock after the address
    logic [7:0] ram [0:511];
    always @(posedge CLK) memData <= ram[MEM_ADDR];

    // Serializer: raises done finDelay cycles after SPI_EN, holds it finHold extra cycles after SPI_EN drops
    int finDelay = 3;
    int finHold = 0;
    int finCnt;
    int holdCnt;
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            spiFin  <= 1'b0;
            finCnt  <= 0;
            holdCnt <= 0;
        end else if (SPI_EN && !spiFin) begin
            if (finCnt + 1 >= finDelay) begin
                spiFin  <= 1'b1;
                finCnt  <= 0;
                holdCnt <= finHold;
            end else begin
                finCnt <= finCnt + 1;
            end
        end else if (!SPI_EN && spiFin) begin
            if (holdCnt > 0) holdCnt <= holdCnt - 1;
            else spiFin <= 1'b0;
        end
    end

    // Scoreboard of bytes expected on the SPI interface
    typedef struct packed {
        logic       dc;
        logic [7:0] data;
        logic [8:0] addr;
    } byteRec_t;

    byteRec_t expQ[$];
    byteRec_t rec;
    logic       prevEn = 1'b0;
    logic       prevFin = 1'b0;
    logic [8:0] heldBits;
    int         byteRises = 0;
    int         byteFalls = 0;

    // Monitor: compare each new byte against the scoreboard, and check the handshake rules
    always @(negedge CLK) begin
        if (SPI_EN && !prevEn) begin
            byteRises++;
            checkOutput("handshake_fin_low", {prevFin, spiFin}, 2'b00);
            checkOutput("byte_expected", expQ.size() != 0, 1);
            if (expQ.size() != 0) begin
                rec = expQ.pop_front();
                checkOutput("spi_data", SPI_DATA, rec.data);
                checkOutput("dc", DC, rec.dc);
                if (rec.dc) checkOutput("mem_addr", MEM_ADDR, rec.addr);
            end
            heldBits = {DC, SPI_DATA};
        end else if (SPI_EN && prevEn) begin
            checkOutput("data_dc_stable", {DC, SPI_DATA}, heldBits);
        end
        if (!SPI_EN && prevEn) byteFalls++;
        prevEn  = SPI_EN;
        prevFin = spiFin;
    end

    task automatic fillRam(input int mode);
        for (int i = 0; i < 512; i++) begin
            if (mode == 0) ram[i] = 8'(i);
            else if (mode == 1) ram[i] = 8'($urandom);
            else ram[i] = ~8'(i);
        end
    endtask

    task automatic pushUpdate(input int lastAddr);
        byteRec_t r;
        int a;
        for (int pg = 0; pg < 4; pg++) begin
            if (pg * 128 > lastAddr) break;
            r.dc = 1'b0;
            r.addr = 9'd0;
            r.data = 8'h22; expQ.push_back(r);
            r.data = 8'(pg); expQ.push_back(r);
            r.data = 8'h00; expQ.push_back(r);
            r.data = 8'h10; expQ.push_back(r);
            for (int c = 0; c < 128; c++) begin
                a = pg * 128 + c;
                if (a > lastAddr) break;
                r.dc = 1'b1;
                r.addr = 9'(a);
`ifdef OLED_PW_INVERT_EN
                r.data = ~ram[a];
`else
                r.data = ram[a];
`endif
                expQ.push_back(r);
            end
        end
    endtask

    task automatic doReset();
        EN = 1'b0;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        expQ.delete();
        byteRises = 0;
        byteFalls = 0;
    endtask

    task automatic waitFin(input int budget);
        logic found;
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge CLK);
            if (FIN) found = 1'b1;
        end
        checkOutput("fin_within_budget", found, 1);
    endtask

    task automatic waitByteAt(input logic [8:0] addr, input int budget);
        logic found;
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge CLK);
            if (SPI_EN && DC && MEM_ADDR == addr) found = 1'b1;
        end
        checkOutput("reach_data_byte", found, 1);
    endtask

    typedef struct {
        int   ramMode;
        int   holdCycles;
        int   expBytes;
        logic expFin;
        logic expBusy;
    } vec_t;

    task automatic applyStimulus(input vec_t v);
        finHold = v.holdCycles;
        fillRam(v.ramMode);
        doReset();
        pushUpdate(511);
        EN = 1'b1;
        waitFin(30000);
        checkOutput("fin_done", FIN, v.expFin);
        checkOutput("busy_done", BUSY, v.expBusy);
        checkOutput("byte_count", byteRises, v.expBytes);
        checkOutput("queue_drained", expQ.size(), 0);
        repeat (3) @(negedge CLK);
        checkOutput("fin_held_with_en", FIN, v.expFin);
        EN = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("fin_after_en_low", FIN, 0);
        checkOutput("busy_idle", BUSY, 0);
    endtask

    vec_t vecs[3];
    int   risesBefore;

    initial begin
        vecs[0] = '{0, 0, 528, 1'b1, 1'b0};
        vecs[1] = '{1, 4, 528, 1'b1, 1'b0};
        vecs[2] = '{2, 1, 528, 1'b1, 1'b0};

        // Reset values before any clock edge
        #1 RST_N = 1'b0;
        #1;
        checkOutput("rst_spi_en", SPI_EN, 0);
        checkOutput("rst_spi_data", SPI_DATA, 0);
        checkOutput("rst_dc", DC, 0);
        checkOutput("rst_busy", BUSY, 0);
        checkOutput("rst_fin", FIN, 0);
        checkOutput("rst_mem_addr", MEM_ADDR, 0);

        // Full updates under different frame contents and serializer hold times
        for (int i = 0; i < 3; i++) applyStimulus(vecs[i]);

        // EN dropped during the data byte at 0x045: that byte completes, nothing follows
        finHold = 0;
        fillRam(0);
        doReset();
        pushUpdate(9'h045);
        EN = 1'b1;
        waitByteAt(9'h045, 5000);
        EN = 1'b0;
        repeat (40) @(negedge CLK);
        checkOutput("abort_rises", byteRises, 74);
        checkOutput("abort_falls", byteFalls, 74);
        checkOutput("abort_queue", expQ.size(), 0);
        checkOutput("abort_spi_en", SPI_EN, 0);
        checkOutput("abort_busy", BUSY, 0);
        checkOutput("abort_fin", FIN, 0);
        checkOutput("abort_dc", DC, 0);

        // Reset pulsed while a byte is in flight: outputs drop without a clock edge
        fillRam(0);
        doReset();
        pushUpdate(511);
        EN = 1'b1;
        waitByteAt(9'h010, 5000);
        #2;
        RST_N = 1'b0;
        EN = 1'b0;
        #1;
        checkOutput("async_rst_spi_en", SPI_EN, 0);
        checkOutput("async_rst_dc", DC, 0);
        checkOutput("async_rst_busy", BUSY, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        risesBefore = byteRises;
        repeat (10) @(negedge CLK);
        checkOutput("idle_after_rst_busy", BUSY, 0);
        checkOutput("idle_after_rst_rises", byteRises, risesBefore);
        expQ.delete();
        byteRises = 0;
        pushUpdate(511);
        EN = 1'b1;
        waitFin(30000);
        checkOutput("restart_byte_count", byteRises, 528);
        checkOutput("restart_queue", expQ.size(), 0);
        EN = 1'b0;
        repeat (3) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/oled_page_writer.md
OLED_PAGE_WRITER -- requirements
Module: oled_page_writer

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port RST_N, input, 1; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port EN, input, 1, level request to refresh the display; raised only after the OLED init sequence reports done.
REQ-004 SHALL have port MEM_ADDR, output, 9, frame-buffer read address = {page[1:0], column[6:0]}.
REQ-005 SHALL have port MEM_DATA, input, 8, frame-buffer byte, valid exactly one CLK after MEM_ADDR changes (synchronous RAM).
REQ-006 SHALL have port SPI_EN, output, 1, byte-transfer request to the SPI serializer.
REQ-007 SHALL have port SPI_DATA, output, 8, byte to transmit; stable whenever SPI_EN=1.
REQ-008 SHALL have port SPI_FIN, input, 1, serializer done; high after the byte shifts out, held high until SPI_EN falls.
REQ-009 SHALL have port DC, output, 1, OLED data/command select: 0 = command, 1 = display data.
REQ-010 SHALL have port BUSY, output, 1, high from update start until return to IDLE or DONE.
REQ-011 SHALL have port FIN, output, 1, high in DONE while EN=1.

Function
REQ-012 SHALL use states IDLE, CMD, FETCH, LOAD, XFER, CLEAR, NEXT, DONE.
REQ-013 IDLE: with EN=1, SHALL clear page=0, col=0, cmd_idx=0, set DC=0, BUSY=1, then go to CMD.
REQ-014 CMD: SHALL load SPI_DATA with cmd_idx 0..3 as 0x22, page (0x00..0x03), 0x00, 0x10; set SPI_EN=1; go to XFER.
REQ-015 After cmd_idx=3 completes, SHALL set DC=1 and go to FETCH.
REQ-016 FETCH: SHALL drive MEM_ADDR={page,col} and go to LOAD; LOAD SHALL latch MEM_DATA into SPI_DATA, set SPI_EN=1, go to XFER (2 cycles from FETCH to SPI_EN high).
REQ-017 XFER: SHALL hold SPI_EN=1 and SPI_DATA constant until SPI_FIN=1, then go to CLEAR.
REQ-018 CLEAR: SHALL drive SPI_EN=0 and remain until SPI_FIN=0 (min 1 cycle), then go to NEXT.
REQ-019 DC SHALL change only while SPI_EN=0.
REQ-020 NEXT (command phase): cmd_idx<3 -> cmd_idx+1, go to CMD.
REQ-021 NEXT (data phase): col<127 -> col+1, FETCH; col=127 and page<3 -> col=0, page+1, cmd_idx=0, DC=0, CMD; col=127 and page=3 -> DONE.
REQ-022 Counters SHALL be 7-bit col and 2-bit page; wrap occurs only through REQ-021, never by overflow.
REQ-023 DONE: SHALL set BUSY=0; EN=1 -> FIN=1; EN=0 -> FIN=0, go to IDLE.
REQ-024 EN falling mid-update SHALL NOT abort an in-flight byte; on reaching NEXT with EN=0, SHALL go to IDLE with DC=0, BUSY=0, FIN=0.
REQ-025 A full update SHALL send exactly 16 command bytes and 512 data bytes in ascending address order.

Reset
REQ-026 RST_N=0 SHALL immediately force state=IDLE, SPI_EN=0, SPI_DATA=0x00, DC=0, BUSY=0, FIN=0, MEM_ADDR=0, page=col=cmd_idx=0.
REQ-027 Reset mid-transfer SHALL drop SPI_EN asynchronously; after release the block SHALL wait in IDLE for EN.

Configuration
REQ-028 With macro OLED_PW_INVERT_EN defined, LOAD SHALL latch ~MEM_DATA (command bytes unaffected); without it, MEM_DATA unmodified.

Verification
REQ-029 Reset, EN=1, serializer model asserting SPI_FIN 3 cycles after SPI_EN -> bytes 0x22,0x00,0x00,0x10 at DC=0, then 128 data bytes at DC=1, MEM_ADDR 0x000..0x07F.
REQ-030 RAM preloaded with data = addr[7:0] -> 528 bytes captured; page 3 command byte 2 = 0x03; last data byte 0xFF from 0x1FF; FIN=1, BUSY=0.
REQ-031 SPI_FIN held high 5 cycles after SPI_EN falls -> SPI_EN stays 0 those 5 cycles; next SPI_EN no earlier than 1 cycle after SPI_FIN=0.
REQ-032 EN dropped during data byte at addr 0x045 -> that byte completes, no further SPI_EN, IDLE with BUSY=0, FIN=0.
REQ-033 RST_N pulsed low while SPI_EN=1 -> SPI_EN, DC, BUSY go 0 without a clock edge; re-raised EN restarts at page 0 command 0x22.
REQ-034 OLED_PW_INVERT_EN defined, MEM_DATA=0x0F at addr 0 -> SPI_DATA=0xF0; commands still 0x22,0x00,0x00,0x10.
